// File: rtl/block_data_mem.sv
// Clocked block-granular main memory behind the cache miss/evict FSM.
// Define BLOCK_DATA_MEM_WRITE_EN to enable the block write-back path; otherwise read-only.
module block_data_mem #(
    parameter int ADDR_W          = 15,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int READ_LATENCY    = 8,
    parameter int WRITE_LATENCY   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_W-1:0]                 address,
    input  logic                              memRead,
    input  logic                              memWrite,
    input  logic [WORDS_PER_BLOCK*DATA_W-1:0] wrData,
    output logic [WORDS_PER_BLOCK*DATA_W-1:0] rdData,
    output logic                              dataRdy,
    output logic                              busy
);

    localparam int OFF    = $clog2(WORDS_PER_BLOCK);
    localparam int MAXLAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                              state, state_nxt;
    logic [CW-1:0]                       cnt;
    logic [ADDR_W-1:0]                   base, req_base;
    logic [WORDS_PER_BLOCK*DATA_W-1:0]   blk_rd;
    logic                                wr_req;
    logic                                fin;
    logic                                unused_addr;

    assign req_base    = {address[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign unused_addr = ^address[OFF-1:0];
    assign fin         = (cnt == '0);

`ifdef BLOCK_DATA_MEM_WRITE_EN
    localparam int DEPTH = 1 << ADDR_W;

    // Words are stored XOR'd with their own address, so the all-zero
    // power-up image reads back as mem[i] = i without any init loop.
    logic [DATA_W-1:0]                 mem [DEPTH] = '{default: '0};
    logic [WORDS_PER_BLOCK*DATA_W-1:0] wbuf;

    assign wr_req = memWrite;

    always_ff @(posedge clk) begin
        if (state == IDLE && wr_req)
            wbuf <= wrData;
    end

    // No reset here: rst aborts the FSM, so an aborted write never reaches this edge.
    always_ff @(posedge clk) begin
        if (state == WR_WAIT && fin) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++)
                mem[base | ADDR_W'(k)] <= wbuf[k*DATA_W +: DATA_W] ^ DATA_W'(base | ADDR_W'(k));
        end
    end
`else
    logic unused_wr;

    assign wr_req    = 1'b0;
    assign unused_wr = ^{memWrite, wrData};
`endif

    for (genvar k = 0; k < WORDS_PER_BLOCK; k++) begin : g_word
        logic [ADDR_W-1:0] idx;
        assign idx = base | ADDR_W'(k);
`ifdef BLOCK_DATA_MEM_WRITE_EN
        assign blk_rd[k*DATA_W +: DATA_W] = mem[idx] ^ DATA_W'(idx);
`else
        assign blk_rd[k*DATA_W +: DATA_W] = DATA_W'(idx);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_req)
                    state_nxt = WR_WAIT;
                else if (memRead)
                    state_nxt = RD_WAIT;
            end
            RD_WAIT: if (fin) state_nxt = DONE;
            WR_WAIT: if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            base    <= '0;
            rdData  <= '0;
            dataRdy <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        base <= req_base;
                        cnt  <= CW'(WRITE_LATENCY - 1);
                        busy <= 1'b1;
                    end else if (memRead) begin
                        base <= req_base;
                        cnt  <= CW'(READ_LATENCY - 1);
                        busy <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (fin) begin
                        rdData  <= blk_rd;
                        dataRdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (fin)
                        dataRdy <= 1'b1;
                    else
                        cnt <= cnt - 1'b1;
                end
                DONE: begin
                    dataRdy <= 1'b0;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_data_mem.sv
// Directed bench for block_data_mem: vector table of block transactions plus reset-abort sequences.
// Write-path cases are compiled only when BLOCK_DATA_MEM_WRITE_EN is defined.
module tb_block_data_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic [14:0]  address;
    logic         memRead;
    logic         memWrite;
    logic [127:0] wrData;
    logic [127:0] rdData;
    logic         dataRdy;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_data_mem dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .memRead  (memRead),
        .memWrite (memWrite),
        .wrData   (wrData),
        .rdData   (rdData),
        .dataRdy  (dataRdy),
        .busy     (busy)
    );

    typedef struct {
        logic [14:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   nvec;

    function automatic logic [127:0] blk(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One accepted transaction; request stays asserted with a scrambled
    // address/data until completion to prove mid-flight changes are ignored.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        address  = v.addr;
        memRead  = v.rd;
        memWrite = v.wr;
        wrData   = v.wd;
        @(posedge clk);
        #1;
        check({tag, " busy_at_accept"}, 128'(busy), 128'(1));
        address = v.addr ^ 15'h0104;
        wrData  = ~v.wd;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (dataRdy) break;
        end
        memRead  = 1'b0;
        memWrite = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(8));
        check({tag, " rdData"}, rdData, v.exp);
        @(posedge clk);
        #1;
        check({tag, " pulse_width"}, 128'(dataRdy), 128'(0));
        check({tag, " busy_clear"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic seen;
        rst      = 1'b1;
        address  = '0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        wrData   = '0;
        #2;
        check("reset rdData", rdData, 128'(0));
        check("reset dataRdy", 128'(dataRdy), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{15'h0006, 1'b1, 1'b0, 128'(0), blk(32'h4, 32'h5, 32'h6, 32'h7)};
        vecs[1] = '{15'h7FFF, 1'b1, 1'b0, 128'(0), blk(32'h7FFC, 32'h7FFD, 32'h7FFE, 32'h7FFF)};
        vecs[2] = '{15'h0000, 1'b1, 1'b0, 128'(0), blk(32'h0, 32'h1, 32'h2, 32'h3)};
        vecs[3] = '{15'h1235, 1'b1, 1'b0, 128'(0), blk(32'h1234, 32'h1235, 32'h1236, 32'h1237)};
`ifdef BLOCK_DATA_MEM_WRITE_EN
        vecs[4] = '{15'h0010, 1'b0, 1'b1, blk(32'hA, 32'hB, 32'hC, 32'hD), blk(32'h1234, 32'h1235, 32'h1236, 32'h1237)};
        vecs[5] = '{15'h0013, 1'b1, 1'b0, 128'(0), blk(32'hA, 32'hB, 32'hC, 32'hD)};
        vecs[6] = '{15'h0020, 1'b1, 1'b1, blk(32'hE0, 32'hE1, 32'hE2, 32'hE3), blk(32'hA, 32'hB, 32'hC, 32'hD)};
        vecs[7] = '{15'h0021, 1'b1, 1'b0, 128'(0), blk(32'hE0, 32'hE1, 32'hE2, 32'hE3)};
        nvec = 8;
`else
        vecs[4] = '{15'h0020, 1'b1, 1'b1, blk(32'hE0, 32'hE1, 32'hE2, 32'hE3), blk(32'h20, 32'h21, 32'h22, 32'h23)};
        vecs[5] = '{15'h0011, 1'b1, 1'b0, 128'(0), blk(32'h10, 32'h11, 32'h12, 32'h13)};
        nvec = 6;
`endif

        for (int i = 0; i < nvec; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

`ifdef BLOCK_DATA_MEM_WRITE_EN
        // Write to 0x0008 aborted by reset must leave memory untouched.
        @(negedge clk);
        address  = 15'h0008;
        memWrite = 1'b1;
        wrData   = blk(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D);
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("wr_abort busy", 128'(busy), 128'(0));
        check("wr_abort dataRdy", 128'(dataRdy), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_txn('{15'h0008, 1'b1, 1'b0, 128'(0), blk(32'h8, 32'h9, 32'hA, 32'hB)}, "after_wr_abort");
`else
        // Read-only build: a lone memWrite must never start a transaction.
        @(negedge clk);
        address  = 15'h0040;
        memWrite = 1'b1;
        wrData   = blk(32'h1, 32'h2, 32'h3, 32'h4);
        seen     = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || dataRdy) seen = 1'b1;
        end
        memWrite = 1'b0;
        check("ro_write_ignored", 128'(seen), 128'(0));
`endif

        // Read of 0x0004 aborted after 3 cycles: async clear, no late pulse.
        @(negedge clk);
        address = 15'h0004;
        memRead = 1'b1;
        @(posedge clk);
        #1;
        memRead = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rd_abort dataRdy", 128'(dataRdy), 128'(0));
        check("rd_abort busy", 128'(busy), 128'(0));
        check("rd_abort rdData", rdData, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dataRdy) seen = 1'b1;
        end
        check("rd_abort no_pulse", 128'(seen), 128'(0));
        run_txn('{15'h0004, 1'b1, 1'b0, 128'(0), blk(32'h4, 32'h5, 32'h6, 32'h7)}, "after_rd_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
